// File: rtl/key_reset_conditioner.sv
`timescale 1ns/1ps
// key_reset_conditioner
// Board-level input conditioner: synchronises and debounces active-low
// pushbuttons into clean level/press/release signals, and sequences a
// stretched system reset from PLL lock and a dedicated reset key.
module key_reset_conditioner #(
  parameter int NKEYS         = 4,
  parameter int DEBOUNCE_BITS = 16,
  parameter int RESET_HOLD    = 1024,
  parameter int RESET_KEY     = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NKEYS-1:0] keys_in,
  input  logic             pll_locked,
  output logic [NKEYS-1:0] keys_level,
  output logic [NKEYS-1:0] keys_pressed,
  output logic [NKEYS-1:0] keys_released,
  output logic             reset_out,
  output logic             reset_out_n
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX   = '1;
  localparam logic [HOLD_W-1:0]        HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic {
    S_HOLD = 1'b0,
    S_RUN  = 1'b1
  } seq_state_e;

  // ---------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------
  logic [NKEYS-1:0] key_meta, key_sync;
  logic             pll_meta, pll_sync;

  // Two-flop synchronisers; keys idle released (1), lock idle unlocked (0).
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, giving a true two-stage pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_meta <= '1;
      key_sync <= '1;
      pll_meta <= 1'b0;
      pll_sync <= 1'b0;
    end else begin
      key_meta <= keys_in;
      key_sync <= key_meta;
      pll_meta <= pll_locked;
      pll_sync <= pll_meta;
    end
  end

  // ---------------------------------------------------------------------
  // Per-key debounce: level follows the sample only after CNT_MAX+1
  // consecutive mismatching cycles; any agreeing sample restarts the count.
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    logic                     sample;
    logic                     level_q;
    logic                     press_q;
    logic                     release_q;
    logic [DEBOUNCE_BITS-1:0] cnt_q;

    assign sample = ~key_sync[k];

    // Stability counter with level update and one-cycle edge pulses.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (sample == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_q <= cnt_q + DEBOUNCE_BITS'(1);
        end else begin
          cnt_q     <= '0;
          level_q   <= sample;
          press_q   <= sample;
          release_q <= ~sample;
        end
      end
    end

    assign keys_level[k]    = level_q;
    assign keys_pressed[k]  = press_q;
    assign keys_released[k] = release_q;
  end

  // ---------------------------------------------------------------------
  // Reset sequencer
  // ---------------------------------------------------------------------
  seq_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              cause;
  logic              hold_next;

  assign cause = ~pll_sync | keys_level[RESET_KEY];

  // State register and hold counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_HOLD;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Next state: HOLD until RESET_HOLD consecutive cause-free cycles, any
  // cause restarts the window or drops RUN back to HOLD.
  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      S_HOLD: begin
        if (cause) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = S_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_RUN: begin
        if (cause) begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
        end
      end
    endcase
  end

  // Output decode from the next state, so the registered reset lines line
  // up with the state register and never glitch.
  always_comb begin
    hold_next = (state_d == S_HOLD);
  end

  // Registered reset outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reset_out   <= 1'b1;
      reset_out_n <= 1'b0;
    end else begin
      reset_out   <= hold_next;
      reset_out_n <= ~hold_next;
    end
  end

endmodule
